// File: rtl/stack_op_sequencer_if.sv
// Execute/memory-side signal bundle for stack_op_sequencer.
// slave = the sequencer itself, master = the surrounding pipeline.
interface stack_op_sequencer_if;
  logic        int_req;
  logic        call_req;
  logic        ret_req;
  logic        rti_req;
  logic [31:0] ret_pc;
  logic [2:0]  flags_in;
  logic [15:0] pop_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_push;
  logic        mem_pop;
  logic [1:0]  mem_addr_sel;
  logic [1:0]  mem_wsrc_sel;
  logic [31:0] save_pc;
  logic [2:0]  save_flags;
  logic        pc_choose_memory;
  logic        interrupt_out;
  logic        flags_restore;
  logic [2:0]  flags_out;
  logic        stall;
  logic        busy;

  modport slave (
    input  int_req, call_req, ret_req, rti_req, ret_pc, flags_in, pop_data,
    output mem_read, mem_write, mem_push, mem_pop, mem_addr_sel, mem_wsrc_sel,
           save_pc, save_flags, pc_choose_memory, interrupt_out, flags_restore,
           flags_out, stall, busy
  );

  modport master (
    output int_req, call_req, ret_req, rti_req, ret_pc, flags_in, pop_data,
    input  mem_read, mem_write, mem_push, mem_pop, mem_addr_sel, mem_wsrc_sel,
           save_pc, save_flags, pc_choose_memory, interrupt_out, flags_restore,
           flags_out, stall, busy
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// Expands CALL/RET/RTI/interrupt into 16-bit stack push/pop micro-ops and stalls the front end.
// Optional macro INT_MASK_EN adds an interrupt-enable flag cleared on entry and restored by RTI.
module stack_op_sequencer #(
  parameter logic [31:0] VECTOR_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  stack_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_FL, VECTOR, POP_FL, POP_LO, POP_HI
  } state_e;

  typedef enum logic [1:0] {K_CALL, K_INT, K_RET, K_RTI} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic        int_pending_q, int_pending_d;
  logic [31:0] save_pc_q;
  logic [2:0]  save_flags_q;
  logic [2:0]  flags_out_q;
  logic        flags_restore_q;
  logic        accept;
  logic        int_accept;
  logic        int_ok;

  // VECTOR_PC is applied by the memory stage; only pop_data[2:0] carries flags.
  logic unused_bits;
  assign unused_bits = ^{VECTOR_PC, bus.pop_data[15:3]};

`ifdef INT_MASK_EN
  logic int_en_q, int_en_d;

  always_comb begin
    int_en_d = int_en_q;
    if (int_accept)
      int_en_d = 1'b0;
    else if (state_q == POP_HI && kind_q == K_RTI)
      int_en_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) int_en_q <= 1'b1;
    else       int_en_q <= int_en_d;
  end

  assign int_ok = int_en_q;
`else
  assign int_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    accept     = 1'b0;
    int_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rti_req) begin
          state_d = POP_FL;  kind_d = K_RTI;  accept = 1'b1;
        end else if (bus.ret_req) begin
          state_d = POP_LO;  kind_d = K_RET;  accept = 1'b1;
        end else if (bus.call_req) begin
          state_d = PUSH_HI; kind_d = K_CALL; accept = 1'b1;
        end else if (int_pending_q && int_ok) begin
          state_d = PUSH_HI; kind_d = K_INT;  accept = 1'b1; int_accept = 1'b1;
        end
      end
      PUSH_HI: state_d = PUSH_LO;
      PUSH_LO: state_d = (kind_q == K_INT) ? PUSH_FL : IDLE;
      PUSH_FL: state_d = VECTOR;
      VECTOR:  state_d = IDLE;
      POP_FL:  state_d = POP_LO;
      POP_LO:  state_d = POP_HI;
      POP_HI:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A request seen on the accept edge re-arms the pending flag for a later round.
  assign int_pending_d = (int_pending_q & ~int_accept) | bus.int_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      kind_q          <= K_CALL;
      int_pending_q   <= 1'b0;
      save_pc_q       <= 32'h0;
      save_flags_q    <= 3'b000;
      flags_out_q     <= 3'b000;
      flags_restore_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      kind_q          <= kind_d;
      int_pending_q   <= int_pending_d;
      flags_restore_q <= (state_q == POP_FL);
      if (accept) begin
        save_pc_q    <= bus.ret_pc;
        save_flags_q <= bus.flags_in;
      end
      if (state_q == POP_FL)
        flags_out_q <= bus.pop_data[2:0];
    end
  end

  always_comb begin
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.mem_push         = 1'b0;
    bus.mem_pop          = 1'b0;
    bus.mem_addr_sel     = 2'b00;
    bus.mem_wsrc_sel     = 2'b00;
    bus.pc_choose_memory = 1'b0;
    bus.interrupt_out    = 1'b0;
    case (state_q)
      PUSH_HI, PUSH_LO, PUSH_FL: begin
        bus.mem_write    = 1'b1;
        bus.mem_push     = 1'b1;
        bus.mem_addr_sel = 2'b10;
        if (state_q == PUSH_HI)      bus.mem_wsrc_sel = 2'b01;
        else if (state_q == PUSH_LO) bus.mem_wsrc_sel = 2'b10;
      end
      POP_FL, POP_LO, POP_HI: begin
        bus.mem_read         = 1'b1;
        bus.mem_pop          = 1'b1;
        bus.mem_addr_sel     = 2'b10;
        bus.pc_choose_memory = (state_q == POP_HI);
      end
      VECTOR:  bus.interrupt_out = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.stall         = bus.busy | accept;
  assign bus.save_pc       = save_pc_q;
  assign bus.save_flags    = save_flags_q;
  assign bus.flags_out     = flags_out_q;
  assign bus.flags_restore = flags_restore_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a sequence-list reference model.
module tb_stack_op_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  stack_op_sequencer_if bus();

  stack_op_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  localparam int OP_IDLE = 0, OP_PH = 1, OP_PL = 2, OP_PF = 3, OP_VEC = 4,
                 OP_QF = 5, OP_QL = 6, OP_QH = 7, OP_QHR = 8;
  localparam int A_NONE = 0, A_CALL = 1, A_RET = 2, A_RTI = 3, A_INT = 4;

  // Reference model: a queue of upcoming micro-ops plus the latched values.
  int          mq[$];
  bit          m_pending = 1'b0;
  bit          m_int_en = 1'b1;
  logic [31:0] m_save_pc = 32'h0;
  logic [2:0]  m_save_flags = 3'b0;
  logic [2:0]  m_flags_out = 3'b0;
  bit          m_restore = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int cur;
    int acc;
    bit e_push;
    bit e_pop;
    if (chk_en) begin
      cur = (mq.size() != 0) ? mq[0] : OP_IDLE;
      acc = A_NONE;
      if (cur == OP_IDLE) begin
        if (bus.rti_req)                 acc = A_RTI;
        else if (bus.ret_req)            acc = A_RET;
        else if (bus.call_req)           acc = A_CALL;
        else if (m_pending && m_int_en)  acc = A_INT;
      end
      e_push = (cur == OP_PH || cur == OP_PL || cur == OP_PF);
      e_pop  = (cur == OP_QF || cur == OP_QL || cur == OP_QH || cur == OP_QHR);
      chk("m_busy",  32'(bus.busy),      32'(cur != OP_IDLE));
      chk("m_stall", 32'(bus.stall),     32'(cur != OP_IDLE || acc != A_NONE));
      chk("m_write", 32'(bus.mem_write), 32'(e_push));
      chk("m_push",  32'(bus.mem_push),  32'(e_push));
      chk("m_read",  32'(bus.mem_read),  32'(e_pop));
      chk("m_pop",   32'(bus.mem_pop),   32'(e_pop));
      chk("m_addr",  32'(bus.mem_addr_sel), (e_push || e_pop) ? 32'd2 : 32'd0);
      chk("m_wsrc",  32'(bus.mem_wsrc_sel),
          cur == OP_PH ? 32'd1 : (cur == OP_PL ? 32'd2 : 32'd0));
      chk("m_pcc",   32'(bus.pc_choose_memory), 32'(cur == OP_QH || cur == OP_QHR));
      chk("m_intout", 32'(bus.interrupt_out), 32'(cur == OP_VEC));
      chk("m_savepc", bus.save_pc, m_save_pc);
      chk("m_saveflags", 32'(bus.save_flags), 32'(m_save_flags));
      chk("m_flagsout", 32'(bus.flags_out), 32'(m_flags_out));
      chk("m_restore", 32'(bus.flags_restore), 32'(m_restore));

      if (reset) begin
        mq.delete();
        m_pending = 1'b0; m_int_en = 1'b1; m_save_pc = 32'h0;
        m_save_flags = 3'b0; m_flags_out = 3'b0; m_restore = 1'b0;
      end else begin
        if (cur != OP_IDLE) void'(mq.pop_front());
        m_restore = (cur == OP_QF);
        if (cur == OP_QF) m_flags_out = bus.pop_data[2:0];
        if (cur == OP_QHR) m_int_en = 1'b1;
        m_pending = (m_pending && acc != A_INT) || bus.int_req;
        if (acc != A_NONE) begin
          m_save_pc = bus.ret_pc;
          m_save_flags = bus.flags_in;
        end
        case (acc)
          A_CALL: begin mq.push_back(OP_PH); mq.push_back(OP_PL); end
          A_RET:  begin mq.push_back(OP_QL); mq.push_back(OP_QH); end
          A_RTI:  begin mq.push_back(OP_QF); mq.push_back(OP_QL); mq.push_back(OP_QHR); end
          A_INT: begin
            mq.push_back(OP_PH); mq.push_back(OP_PL);
            mq.push_back(OP_PF); mq.push_back(OP_VEC);
`ifdef INT_MASK_EN
            m_int_en = 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    bus.int_req = 0; bus.call_req = 0; bus.ret_req = 0; bus.rti_req = 0;
    bus.ret_pc = 32'h0; bus.flags_in = 3'b0; bus.pop_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_savepc", bus.save_pc, 0);

    // CALL
    tick(); bus.call_req = 1; bus.ret_pc = 32'h0001_2345; bus.flags_in = 3'b101;
    @(negedge clk); chk("call_acc_stall", 32'(bus.stall), 1); chk("call_acc_busy", 32'(bus.busy), 0);
    tick(); bus.call_req = 0;
    @(negedge clk);
    chk("call_hi_push", 32'(bus.mem_push), 1);
    chk("call_hi_wsrc", 32'(bus.mem_wsrc_sel), 1);
    chk("call_hi_savepc", bus.save_pc, 32'h0001_2345);
    chk("call_hi_saveflags", 32'(bus.save_flags), 5);
    tick(); @(negedge clk);
    chk("call_lo_wsrc", 32'(bus.mem_wsrc_sel), 2); chk("call_lo_stall", 32'(bus.stall), 1);
    tick(); @(negedge clk);
    chk("call_end_busy", 32'(bus.busy), 0); chk("call_end_stall", 32'(bus.stall), 0);

    // RET
    tick(); bus.ret_req = 1; bus.pop_data = 16'h2345;
    @(negedge clk); chk("ret_acc_stall", 32'(bus.stall), 1);
    tick(); bus.ret_req = 0;
    @(negedge clk); chk("ret_lo_pop", 32'(bus.mem_pop), 1); chk("ret_lo_pcc", 32'(bus.pc_choose_memory), 0);
    tick(); bus.pop_data = 16'h0001;
    @(negedge clk); chk("ret_hi_pop", 32'(bus.mem_pop), 1); chk("ret_hi_pcc", 32'(bus.pc_choose_memory), 1);
    tick(); @(negedge clk);
    chk("ret_end_pop", 32'(bus.mem_pop), 0); chk("ret_end_pcc", 32'(bus.pc_choose_memory), 0);

    // Interrupt
    tick(); bus.int_req = 1; bus.flags_in = 3'b011; bus.ret_pc = 32'h0000_0456;
    tick(); bus.int_req = 0;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_push === 1'b1) found = 1;
      else tick();
    end
    chk("int_started", 32'(found), 1);
    if (found) begin
      chk("int_hi_wsrc", 32'(bus.mem_wsrc_sel), 1);
      chk("int_saveflags", 32'(bus.save_flags), 3);
      tick(); @(negedge clk); chk("int_lo_wsrc", 32'(bus.mem_wsrc_sel), 2);
      tick(); @(negedge clk); chk("int_fl_wsrc", 32'(bus.mem_wsrc_sel), 0); chk("int_fl_push", 32'(bus.mem_push), 1);
      tick(); @(negedge clk); chk("int_vec_out", 32'(bus.interrupt_out), 1); chk("int_vec_write", 32'(bus.mem_write), 0);
      tick(); @(negedge clk); chk("int_end_out", 32'(bus.interrupt_out), 0); chk("int_end_busy", 32'(bus.busy), 0);
    end

    // RTI
    tick(); bus.rti_req = 1; bus.pop_data = 16'h0006;
    @(negedge clk); chk("rti_acc_stall", 32'(bus.stall), 1);
    tick(); bus.rti_req = 0;
    @(negedge clk); chk("rti_fl_pop", 32'(bus.mem_pop), 1); chk("rti_fl_restore", 32'(bus.flags_restore), 0);
    tick(); bus.pop_data = 16'h1234;
    @(negedge clk);
    chk("rti_flags_out", 32'(bus.flags_out), 6); chk("rti_restore", 32'(bus.flags_restore), 1);
    chk("rti_lo_pcc", 32'(bus.pc_choose_memory), 0);
    tick(); @(negedge clk); chk("rti_hi_pcc", 32'(bus.pc_choose_memory), 1); chk("rti_hi_restore", 32'(bus.flags_restore), 0);
    tick(); @(negedge clk); chk("rti_end_busy", 32'(bus.busy), 0);

    // Simultaneous interrupt and CALL
    tick(); bus.call_req = 1; bus.int_req = 1; bus.ret_pc = 32'hABCD_0000;
    tick(); bus.call_req = 0; bus.int_req = 0;
    @(negedge clk); chk("both_hi_wsrc", 32'(bus.mem_wsrc_sel), 1); chk("both_savepc", bus.save_pc, 32'hABCD_0000);
    tick(); @(negedge clk); chk("both_lo_wsrc", 32'(bus.mem_wsrc_sel), 2);
    tick(); @(negedge clk); chk("both_ret_busy", 32'(bus.busy), 0); chk("both_ret_stall", 32'(bus.stall), 1);
    tick(); @(negedge clk); chk("both_int_hi", 32'(bus.mem_wsrc_sel), 1);
    tick(); tick(); @(negedge clk); chk("both_int_fl", 32'(bus.mem_wsrc_sel), 0);
    tick(); @(negedge clk); chk("both_int_vec", 32'(bus.interrupt_out), 1);
    tick(); @(negedge clk); chk("both_end_busy", 32'(bus.busy), 0);

`ifdef INT_MASK_EN
    // Handler still running (no RTI yet): a new interrupt must be held.
    tick(); bus.int_req = 1;
    tick(); bus.int_req = 0;
    repeat (3) begin @(negedge clk); chk("mask_held", 32'(bus.stall), 0); tick(); end
    bus.rti_req = 1;
    tick(); bus.rti_req = 0;
    tick(); tick(); tick();
    @(negedge clk); chk("mask_after_rti", 32'(bus.stall), 1); chk("mask_after_rti_busy", 32'(bus.busy), 0);
    repeat (5) tick();
`endif

    // Reset during PUSH_LO, with an interrupt pending
    tick(); bus.call_req = 1;
    tick(); bus.call_req = 0; bus.int_req = 1;
    tick(); bus.int_req = 0; reset = 1;
    @(negedge clk); chk("rst_mid_lo_wsrc", 32'(bus.mem_wsrc_sel), 2);
    tick(); reset = 0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(bus.busy), 0); chk("rst_mid_push", 32'(bus.mem_push), 0);
    chk("rst_mid_stall", 32'(bus.stall), 0); chk("rst_mid_addr", 32'(bus.mem_addr_sel), 0);
    chk("rst_mid_flagsout", 32'(bus.flags_out), 0); chk("rst_mid_savepc", bus.save_pc, 0);
    tick(); @(negedge clk); chk("rst_mid_nopend", 32'(bus.stall), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      tick();
      bus.call_req = 0; bus.ret_req = 0; bus.rti_req = 0;
      bus.ret_pc = $urandom;
      bus.flags_in = 3'($urandom);
      bus.pop_data = 16'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      bus.int_req = !reset && ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 17);
      if (!reset) begin
        if (r == 0) bus.call_req = 1;
        else if (r == 1) bus.ret_req = 1;
        else if (r == 2) bus.rti_req = 1;
      end
    end
    tick();
    bus.call_req = 0; bus.ret_req = 0; bus.rti_req = 0; bus.int_req = 0; reset = 0;
    repeat (10) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
